// File: rtl/replace_order_decoder_q_if.sv
// Handshake and decoded-field bundle between the payload framer, the Replace Order decoder
// and the order-book update stage.
interface replace_order_decoder_q_if #(
  parameter int unsigned PAYLOAD_W = 512
);
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] payload;
  logic [7:0]           in_len;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          out_orig_ref;
  logic [63:0]          out_new_ref;
  logic [31:0]          out_shares;
  logic [31:0]          out_price;
  logic [15:0]          out_stock_locate;
  logic [47:0]          out_timestamp;

  modport master (
    output in_valid, payload, in_len, out_ready,
    input  in_ready, out_valid, out_orig_ref, out_new_ref, out_shares, out_price,
           out_stock_locate, out_timestamp
  );

  modport slave (
    input  in_valid, payload, in_len, out_ready,
    output in_ready, out_valid, out_orig_ref, out_new_ref, out_shares, out_price,
           out_stock_locate, out_timestamp
  );
endinterface

// File: rtl/replace_order_decoder_q.sv
// ITCH Replace Order ('U') decoder with length check and a show-ahead FIFO of decoded orders
// behind a valid/ready output.
module replace_order_decoder_q #(
  parameter int unsigned PAYLOAD_W   = 512,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          FULL_LAYOUT = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  replace_order_decoder_q_if.slave bus_if,
  output logic                    replace_order_decoded_o,
  output logic [15:0]             err_count_o,
  output logic [31:0]             msg_count_o
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam int unsigned ReqLen   = FULL_LAYOUT ? 35 : 25;
  localparam int unsigned OrigOff  = FULL_LAYOUT ? 11 : 1;
  localparam int unsigned NewOff   = FULL_LAYOUT ? 19 : 9;
  localparam int unsigned ShrOff   = FULL_LAYOUT ? 27 : 17;
  localparam int unsigned PrcOff   = FULL_LAYOUT ? 31 : 21;
  localparam int unsigned Top      = PAYLOAD_W - 1;

  typedef struct packed {
    logic [63:0] orig_ref;
    logic [63:0] new_ref;
    logic [31:0] shares;
    logic [31:0] price;
    logic [15:0] stock_locate;
    logic [47:0] timestamp;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  entry_t          entry_in;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            decoded_q, decoded_d;
  logic [15:0]     err_count_q, err_count_d;
  logic [31:0]     msg_count_q, msg_count_d;

  logic [7:0] msg_type;
  logic       is_u, len_ok, accept, push, len_err, pop;
  logic       in_ready, out_valid;
  logic       unused_payload;

  // Only a subset of payload bytes is decoded; the rest is intentionally ignored.
  assign unused_payload = ^bus_if.payload;

  // Big-endian multi-byte fields occupy contiguous MSB-first bit ranges.
  always_comb begin
    entry_in              = '0;
    entry_in.orig_ref     = bus_if.payload[Top - 8*OrigOff -: 64];
    entry_in.new_ref      = bus_if.payload[Top - 8*NewOff -: 64];
    entry_in.shares       = bus_if.payload[Top - 8*ShrOff -: 32];
    entry_in.price        = bus_if.payload[Top - 8*PrcOff -: 32];
    if (FULL_LAYOUT) begin
      entry_in.stock_locate = bus_if.payload[Top - 8 -: 16];
      entry_in.timestamp    = bus_if.payload[Top - 40 -: 48];
    end
  end

  assign msg_type  = bus_if.payload[Top -: 8];
  assign is_u      = (msg_type == 8'h55);
  assign len_ok    = (bus_if.in_len >= 8'(ReqLen));
  assign in_ready  = (count_q != DepthCnt);
  assign out_valid = (count_q != '0);
  assign accept    = bus_if.in_valid & in_ready;
  assign push      = accept & is_u & len_ok;
  assign len_err   = accept & is_u & ~len_ok;
  assign pop       = out_valid & bus_if.out_ready;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    decoded_d   = push;
    err_count_d = err_count_q;
    msg_count_d = msg_count_q;
    if (push) begin
      wr_ptr_d    = wr_ptr_q + PtrW'(1);
      msg_count_d = msg_count_q + 32'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (len_err && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      decoded_q   <= 1'b0;
      err_count_q <= '0;
      msg_count_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      decoded_q   <= decoded_d;
      err_count_q <= err_count_d;
      msg_count_q <= msg_count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= entry_in;
      end
    end
  end

  assign bus_if.in_ready         = in_ready;
  assign bus_if.out_valid        = out_valid;
  assign bus_if.out_orig_ref     = mem_q[rd_ptr_q].orig_ref;
  assign bus_if.out_new_ref      = mem_q[rd_ptr_q].new_ref;
  assign bus_if.out_shares       = mem_q[rd_ptr_q].shares;
  assign bus_if.out_price        = mem_q[rd_ptr_q].price;
  assign bus_if.out_stock_locate = mem_q[rd_ptr_q].stock_locate;
  assign bus_if.out_timestamp    = mem_q[rd_ptr_q].timestamp;

  assign replace_order_decoded_o = decoded_q;
  assign err_count_o             = err_count_q;
  assign msg_count_o             = msg_count_q;

endmodule
